// File: rtl/operand_fetch_scoreboard.sv
// Issue-side operand fetch: register file read and write ports, same-cycle
// writeback forwarding, busy-bit scoreboard for RAW/WAW hazards, and a
// one-entry registered operand stage.
module operand_fetch_scoreboard #(
  parameter int unsigned DIR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIR_WIDTH-1:0]  in_rs1,
  input  logic [DIR_WIDTH-1:0]  in_rs2,
  input  logic [DIR_WIDTH-1:0]  in_rd,
  input  logic                  in_rd_we,
  output logic [DIR_WIDTH-1:0]  rf_read_dir1,
  output logic [DIR_WIDTH-1:0]  rf_read_dir2,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2,
  output logic                  rf_write_en,
  output logic [DIR_WIDTH-1:0]  rf_write_dir,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  input  logic                  wb_valid,
  input  logic [DIR_WIDTH-1:0]  wb_dir,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [DIR_WIDTH-1:0]  out_rd,
  output logic                  out_rd_we,
  output logic                  stall
);

  localparam int unsigned NUM_REGS = 1 << DIR_WIDTH;

  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  rs1_zero;
  logic                  rs2_zero;
  logic                  rd_live;
  logic                  wb_live;
  logic                  wb_hit1;
  logic                  wb_hit2;
  logic                  wb_hit_rd;
  logic                  src1_ok;
  logic                  src2_ok;
  logic                  waw_ok;
  logic                  accept;
  logic [DATA_WIDTH-1:0] op1;
  logic [DATA_WIDTH-1:0] op2;

  // Register file ports pass straight through; register 0 is never written.
  assign rf_read_dir1  = in_rs1;
  assign rf_read_dir2  = in_rs2;
  assign rf_write_en   = wb_live;
  assign rf_write_dir  = wb_dir;
  assign rf_write_data = wb_data;

  // Hazard detection, forwarding and handshake.
  always_comb begin
    rs1_zero  = (in_rs1 == '0);
    rs2_zero  = (in_rs2 == '0);
    rd_live   = in_rd_we && (in_rd != '0);
    wb_live   = wb_valid && (wb_dir != '0);
    wb_hit1   = wb_valid && (wb_dir == in_rs1);
    wb_hit2   = wb_valid && (wb_dir == in_rs2);
    wb_hit_rd = wb_valid && (wb_dir == in_rd);

    op1 = rs1_zero ? '0 : (wb_hit1 ? wb_data : rf_read_data1);
    op2 = rs2_zero ? '0 : (wb_hit2 ? wb_data : rf_read_data2);

    src1_ok = rs1_zero || !busy_q[in_rs1] || wb_hit1;
    src2_ok = rs2_zero || !busy_q[in_rs2] || wb_hit2;
    waw_ok  = !rd_live || !busy_q[in_rd] || wb_hit_rd;

    in_ready = arst_n && src1_ok && src2_ok && waw_ok && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    stall    = in_valid && !in_ready;
  end

  // Scoreboard next state: writeback clears, accept sets, set wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_live) begin
      busy_d[wb_dir] = 1'b0;
    end
    if (accept && rd_live) begin
      busy_d[in_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // One-entry operand stage; an accept while draining replaces the bundle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_rd_we <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op1   <= op1;
      out_op2   <= op2;
      out_rd    <= in_rd;
      out_rd_we <= in_rd_we;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch_scoreboard.md
# operand_fetch_scoreboard

Issue-side front end of the physical register file. It accepts decoded instructions over a valid/ready handshake and reads both source operands from the register file. It forwards same-cycle writeback data, stalls on read-after-write and write-after-write hazards using a per-register busy scoreboard, and registers the operands into a one-entry output stage. It also owns the register file write port and retires writebacks into it.

## Interface
- DIR_WIDTH, 5, register address width; 2**DIR_WIDTH architectural registers, register 0 hardwired to zero
- DATA_WIDTH, 32, operand/result width
- clk  in  1  clock, all state updates on rising edge
- arst_n  in  1  asynchronous reset, active low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- in_rs1, in_rs2  in  DIR_WIDTH  source register addresses
- in_rd  in  DIR_WIDTH  destination register address
- in_rd_we  in  1  instruction will write in_rd
- rf_read_dir1, rf_read_dir2  out  DIR_WIDTH  register file read addresses
- rf_read_data1, rf_read_data2  in  DATA_WIDTH  register file combinational read data
- rf_write_en  out  1  register file write enable
- rf_write_dir  out  DIR_WIDTH  register file write address
- rf_write_data  out  DATA_WIDTH  register file write data
- wb_valid  in  1  writeback result present (always consumed, no backpressure)
- wb_dir  in  DIR_WIDTH  writeback destination
- wb_data  in  DATA_WIDTH  writeback value
- out_valid  out  1  operand bundle valid
- out_ready  in  1  downstream consumes bundle when out_valid & out_ready
- out_op1, out_op2  out  DATA_WIDTH  resolved operands
- out_rd  out  DIR_WIDTH  destination address
- out_rd_we  out  1  destination write flag
- stall  out  1  in_valid & ~in_ready

## Operation
- Reads are combinational: rf_read_dir1 = in_rs1 and rf_read_dir2 = in_rs2.
- Writeback is combinational: rf_write_en = wb_valid & (wb_dir != 0), rf_write_dir = wb_dir, rf_write_data = wb_data.
- Scoreboard: busy bit per register 1..2**DIR_WIDTH-1. Register 0 is never busy.
- Operand resolution, per source n:
  - rsn == 0 → 0.
  - else wb_valid & wb_dir == rsn → wb_data (forward; the register file still holds the old value this cycle).
  - else rf_read_datan.
- A source is hazard-free when rsn == 0, or ~busy[rsn], or (wb_valid & wb_dir == rsn).
- Destination WAW check: if in_rd_we & in_rd != 0, then busy[in_rd] must be clear or cleared by a same-cycle writeback.
- in_ready = both sources hazard-free & WAW clear & (~out_valid | out_ready).
- On accept:
  - Load out_op1/out_op2/out_rd/out_rd_we and set out_valid.
  - Set busy[in_rd] if in_rd_we & in_rd != 0.
- On wb_valid & wb_dir != 0: clear busy[wb_dir].
  - If the same register is also set by an accept in that cycle, set wins.
  - A writeback to a non-busy register writes the register file and leaves the scoreboard unchanged.
- Output stage: when out_valid & out_ready and no new accept, out_valid → 0. Accept while draining replaces the bundle in the same edge (full throughput).
- in_rd_we with in_rd == 0: bundle passes with out_rd_we = 1, out_rd = 0, and no busy bit is set.

## Timing
- Reset (asynchronous, arst_n low) forces:
  - out_valid 0; out_op1, out_op2, out_rd, out_rd_we 0.
  - All busy bits 0.
- rf_* outputs and stall are combinational, so they follow inputs during reset. in_ready is forced 0 while arst_n is low.
- Reset mid-operation discards the held bundle and all pending scoreboard entries. Writebacks after reset do not set anything.
- Latency: accept at edge N → out_valid high after edge N, holding the operands captured at edge N.
- out_* is stable while out_valid & ~out_ready. in_ready is 0 in that state.
- Forwarding window is exactly the writeback cycle. From the next cycle on, the register file supplies the value.
- Back-to-back dependent issue: an instruction reading rd of the previous one stalls until the cycle wb_valid carries that rd, then issues in that same cycle.

## Test plan
- Reset, then write x5 = 0xDEADBEEF via wb, then issue rs1 = 5, rs2 = 0 → next cycle out_valid = 1, out_op1 = 0xDEADBEEF, out_op2 = 0.
- Issue rd = 3 (we = 1), then rs1 = 3 → stall = 1 for 4 cycles. wb x3 = 0x1234 in cycle 5 → in_ready = 1 that cycle and out_op1 = 0x1234 (forwarded).
- Issue rd = 7, then rd = 7 again → second instruction stalls (WAW) until wb x7. In the wb cycle it accepts and busy[7] stays 1.
- Hold out_ready = 0 with out_valid = 1 → in_ready = 0 and out_* unchanged for 3 cycles. Raise out_ready with a new valid instruction → bundle replaced at the next edge, no bubble.
- wb_valid with wb_dir = 0, wb_data = 0xFFFFFFFF → rf_write_en = 0. A later read of rs1 = 0 returns 0.
- Issue rd = 9, pull arst_n low for 1 cycle, then issue rs1 = 9 → accepted immediately (busy cleared), and out_valid was 0 during reset.
